// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
//
// Four-phase instruction fetch sequencer. Each instruction slot lasts four
// clk cycles (Stage 0..3). The ROM prefetch address (PC+1) is constant for the
// whole slot. The synchronous ROM word is therefore settled by Stage 3, and it
// is loaded into the instruction register at the Stage 3 edge unless the
// decode stage requests a hold. A two-flop synchroniser brings the external
// handshake level into the clk domain.
//
// Ports
//   clk          in   1  system clock, rising-edge active
//   reset        in   1  synchronous active-high reset, overrides everything
//   PCHold       in   1  decode-stage hold request, honoured only at Stage 3
//   HandshakeIn  in   1  raw asynchronous handshake level
//   ProgData     in  12  program ROM read data (one clk after ProgAddr)
//   ProgAddr     out  8  ROM prefetch address = PC+1 mod 256 (combinational)
//   Instruction  out 12  instruction register contents
//   Stage        out  2  current execution phase 0..3
//   PC           out  8  address of the instruction held in Instruction
//   Handshake    out  1  HandshakeIn after two synchroniser flops
//   Valid        out  1  high once Instruction holds a fetched word
// -----------------------------------------------------------------------------
module fetch_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        PCHold,
  input  logic        HandshakeIn,
  input  logic [11:0] ProgData,
  output logic [7:0]  ProgAddr,
  output logic [11:0] Instruction,
  output logic [1:0]  Stage,
  output logic [7:0]  PC,
  output logic        Handshake,
  output logic        Valid
);

  localparam logic [1:0] ST_ISSUE = 2'd0;  // prefetch address presented
  localparam logic [1:0] ST_WAIT1 = 2'd1;
  localparam logic [1:0] ST_WAIT2 = 2'd2;
  localparam logic [1:0] ST_LOAD  = 2'd3;  // IR load point, may be held

  logic [7:0]  r_pc;
  logic [1:0]  r_stage;
  logic [11:0] r_ir;
  logic        r_valid;
  logic        r_hs_meta;
  logic        r_hs_sync;

  logic [7:0]  w_pc_inc;
  logic        w_load;
  logic [1:0]  w_stage_next;

  // PC resets to 8'hFF so that the first prefetch address is 8'h00.
  assign w_pc_inc = r_pc + 8'd1;

  // PCHold is only looked at in the load phase; earlier phases always advance.
  assign w_load = (r_stage == ST_LOAD) && !PCHold;

  always_comb begin
    w_stage_next = r_stage;
    case (r_stage)
      ST_ISSUE: w_stage_next = ST_WAIT1;
      ST_WAIT1: w_stage_next = ST_WAIT2;
      ST_WAIT2: w_stage_next = ST_LOAD;
      ST_LOAD:  w_stage_next = PCHold ? ST_LOAD : ST_ISSUE;
      default:  w_stage_next = ST_ISSUE;
    endcase
  end

  // Phase counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stage <= ST_ISSUE;
    end else begin
      r_stage <= w_stage_next;
    end
  end

  // PC, instruction register and valid flag change only at an unheld load.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc    <= 8'hFF;
      r_ir    <= 12'h000;
      r_valid <= 1'b0;
    end else if (w_load) begin
      r_pc    <= w_pc_inc;
      r_ir    <= ProgData;
      r_valid <= 1'b1;
    end
  end

  // Handshake synchroniser; runs every cycle regardless of hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hs_meta <= 1'b0;
      r_hs_sync <= 1'b0;
    end else begin
      r_hs_meta <= HandshakeIn;
      r_hs_sync <= r_hs_meta;
    end
  end

  assign ProgAddr    = w_pc_inc;
  assign Instruction = r_ir;
  assign Stage       = r_stage;
  assign PC          = r_pc;
  assign Handshake   = r_hs_sync;
  assign Valid       = r_valid;

endmodule

// File: tb/tb_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fetch_sequencer
//
// Self-checking bench for fetch_sequencer. A synchronous ROM model feeds
// ProgData. A slot-level reference model predicts PC, Stage, Instruction,
// Valid, ProgAddr and Handshake after every clock edge. Directed scenarios
// cover reset, the first two fetches, holds, wrap and reset-in-hold. They are
// followed by randomized hold/handshake/reset stimulus.
// -----------------------------------------------------------------------------
module tb_fetch_sequencer;

  logic        clk;
  logic        reset;
  logic        PCHold;
  logic        HandshakeIn;
  logic [11:0] ProgData;
  logic [7:0]  ProgAddr;
  logic [11:0] Instruction;
  logic [1:0]  Stage;
  logic [7:0]  PC;
  logic        Handshake;
  logic        Valid;

  fetch_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .PCHold     (PCHold),
    .HandshakeIn(HandshakeIn),
    .ProgData   (ProgData),
    .ProgAddr   (ProgAddr),
    .Instruction(Instruction),
    .Stage      (Stage),
    .PC         (PC),
    .Handshake  (Handshake),
    .Valid      (Valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous program ROM: data appears one clk after the address.
  logic [11:0] rom [256];
  always @(posedge clk) ProgData <= rom[ProgAddr];

  // Reference model state (plain integers, slot-level rules).
  int m_pc;
  int m_stage;
  int m_ir;
  int m_valid;
  int m_hs;
  int m_hs_prev;

  int n_checks;
  int n_fail;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Model one rising edge using the inputs that were stable before it.
  task automatic model_edge(input logic rst_v, input logic hold_v, input logic hs_v);
    if (rst_v) begin
      m_pc = 255; m_stage = 0; m_ir = 0; m_valid = 0;
      m_hs = 0; m_hs_prev = 0;
    end else begin
      // Handshake shows the input level seen one edge before this one.
      m_hs      = m_hs_prev;
      m_hs_prev = int'(hs_v);
      if (m_stage == 3) begin
        if (!hold_v) begin
          m_pc    = (m_pc + 1) % 256;
          m_ir    = int'(rom[m_pc]);
          m_stage = 0;
          m_valid = 1;
          $display("load pc=%02h ir=%03h", m_pc, m_ir);
        end
      end else begin
        m_stage = m_stage + 1;
      end
    end
  endtask

  task automatic check_all();
    check_value("stage",  32'(Stage),       32'(m_stage));
    check_value("pc",     32'(PC),          32'(m_pc));
    check_value("instr",  32'(Instruction), 32'(m_ir));
    check_value("valid",  32'(Valid),       32'(m_valid));
    check_value("paddr",  32'(ProgAddr),    32'((m_pc + 1) % 256));
    check_value("hshake", 32'(Handshake),   32'(m_hs));
  endtask

  // One clock: advance model with the current inputs, then compare after the edge.
  task automatic tick();
    logic r_v, h_v, s_v;
    r_v = reset; h_v = PCHold; s_v = HandshakeIn;
    @(posedge clk);
    model_edge(r_v, h_v, s_v);
    #1;
    check_all();
  endtask

  // Bounded wait until the model (and DUT) sits in Stage 3.
  task automatic run_to_stage3();
    int budget;
    budget = 0;
    PCHold = 1'b0;
    while (m_stage != 3 && budget < 8) begin
      tick();
      budget++;
    end
    check_value("reach_st3", 32'(m_stage == 3), 32'd1);
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    m_pc = 255; m_stage = 0; m_ir = 0; m_valid = 0; m_hs = 0; m_hs_prev = 0;
    for (int i = 0; i < 256; i++) rom[i] = 12'($urandom);
    rom[0] = 12'hABC;
    rom[1] = 12'h123;
    reset = 1'b1; PCHold = 1'b0; HandshakeIn = 1'b0;

    // Reset state
    tick(); tick();
    check_value("rst_stage", 32'(Stage), 32'd0);
    check_value("rst_pc",    32'(PC), 32'hFF);
    check_value("rst_valid", 32'(Valid), 32'd0);
    check_value("rst_instr", 32'(Instruction), 32'h000);
    check_value("rst_paddr", 32'(ProgAddr), 32'h00);
    reset = 1'b0;

    // First two fetches
    for (int c = 1; c <= 8; c++) begin
      tick();
      check_value("seq_stage", 32'(Stage), 32'(c % 4));
      if (c == 3) check_value("valid_low_c3", 32'(Valid), 32'd0);
      if (c == 4) begin
        check_value("c4_instr", 32'(Instruction), 32'hABC);
        check_value("c4_pc",    32'(PC), 32'h00);
        check_value("c4_valid", 32'(Valid), 32'd1);
      end
    end
    check_value("c8_instr", 32'(Instruction), 32'h123);
    check_value("c8_pc",    32'(PC), 32'h01);

    // Hold asserted only in stages 0..2 must not stall
    for (int c = 0; c < 12; c++) begin
      PCHold = (m_stage != 3);
      tick();
    end
    PCHold = 1'b0;

    // Hold at Stage 3 for 5 cycles, with a handshake rise inside the hold
    HandshakeIn = 1'b0;
    tick(); tick();
    run_to_stage3();
    begin
      int ir_save, pc_save;
      ir_save = m_ir; pc_save = m_pc;
      PCHold = 1'b1;
      tick();
      HandshakeIn = 1'b1;
      for (int c = 2; c <= 5; c++) begin
        tick();
        check_value("hold_stage", 32'(Stage), 32'd3);
        check_value("hold_instr", 32'(Instruction), 32'(ir_save));
        check_value("hold_pc",    32'(PC), 32'(pc_save));
        if (c == 2) check_value("hs_one_edge", 32'(Handshake), 32'd0);
        if (c == 3) check_value("hs_two_edge", 32'(Handshake), 32'd1);
      end
      PCHold = 1'b0;
      tick();
      check_value("unhold_stage", 32'(Stage), 32'd0);
      check_value("unhold_pc",    32'(PC), 32'((pc_save + 1) % 256));
      check_value("unhold_instr", 32'(Instruction), 32'(rom[(pc_save + 1) % 256]));
    end

    // Randomized holds, handshake and occasional reset
    for (int c = 0; c < 400; c++) begin
      PCHold      = 1'($urandom_range(0, 1));
      HandshakeIn = 1'($urandom_range(0, 1));
      reset       = ($urandom_range(0, 49) == 0);
      tick();
    end
    reset = 1'b0;

    // Run unheld through a full PC wrap
    reset = 1'b1; tick(); reset = 1'b0;
    PCHold = 1'b0;
    for (int c = 0; c < 256 * 4 + 8; c++) begin
      HandshakeIn = 1'($urandom_range(0, 1));
      tick();
      if (m_pc == 255 && m_valid == 1) check_value("wrap_paddr", 32'(ProgAddr), 32'h00);
    end

    // Reset during a hold at Stage 3
    run_to_stage3();
    PCHold = 1'b1;
    tick();
    reset = 1'b1;
    tick();
    check_value("rh_stage", 32'(Stage), 32'd0);
    check_value("rh_pc",    32'(PC), 32'hFF);
    check_value("rh_valid", 32'(Valid), 32'd0);
    check_value("rh_paddr", 32'(ProgAddr), 32'h00);
    reset = 1'b0; PCHold = 1'b0;
    for (int c = 0; c < 8; c++) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 The module SHALL have the port `clk`, an input of width 1: the single system clock; all state changes on its rising edge.
REQ-002 The module SHALL have the port `reset`, an input of width 1: a synchronous, active-high reset, sampled on the `clk` rising edge.
REQ-003 The module SHALL have the port `PCHold`, an input of width 1: the hold request from the decode stage, honoured only when `Stage`==3.
REQ-004 The module SHALL have the port `HandshakeIn`, an input of width 1: the raw, asynchronous external handshake level.
REQ-005 The module SHALL have the port `ProgData`, an input of width 12: program ROM read data, valid one `clk` after `ProgAddr` is presented (synchronous ROM).
REQ-006 The module SHALL have the port `ProgAddr`, an output of width 8: the program ROM prefetch address, equal to PC+1 mod 256, combinational from the PC register.
REQ-007 The module SHALL have the port `Instruction`, an output of width 12: the instruction register (IR) contents, feeding the decode stage.
REQ-008 The module SHALL have the port `Stage`, an output of width 2: the current execution phase, 0..3.
REQ-009 The module SHALL have the port `PC`, an output of width 8: the address of the instruction currently held in IR.
REQ-010 The module SHALL have the port `Handshake`, an output of width 1: `HandshakeIn` after a 2-flop synchroniser.
REQ-011 The module SHALL have the port `Valid`, an output of width 1: high once IR holds a fetched instruction; the top level gates RegWrite/ACCWE with it.
REQ-012 The module SHALL have no parameters; all widths SHALL be fixed as listed.

Function
REQ-013 The stage counter SHALL advance 0->1->2->3->0, one step per `clk`, when not holding.
REQ-014 At `Stage`==0, 1 or 2, `PCHold` SHALL be ignored; the counter SHALL always advance.
REQ-015 At the `Stage`==3 edge with `PCHold`=0, IR SHALL load `ProgData`, PC SHALL load PC+1 mod 256, `Stage` SHALL load 0, and `Valid` SHALL load 1.
REQ-016 At the `Stage`==3 edge with `PCHold`=1, `Stage`, IR, PC and `Valid` SHALL all hold their values; `Stage` remains 3 until a `Stage`==3 edge with `PCHold`=0.
REQ-017 `ProgAddr` SHALL be constant for the whole 4-cycle slot, so `ProgData` sampled at `Stage`==3 is the word at PC+1.
REQ-018 PC wrap: PC==8'hFF SHALL increment to 8'h00; `ProgAddr` at PC==8'hFF SHALL be 8'h00.
REQ-019 Instruction latency: the word at address A SHALL appear on `Instruction` on the cycle after the `Stage`==3 edge that follows `ProgAddr`==A.
REQ-020 The `Handshake` synchroniser SHALL be two flops in series; `Handshake` SHALL follow `HandshakeIn` after exactly 2 `clk` edges; it SHALL run regardless of hold.
REQ-021 `PCHold` SHALL be combinational from `Instruction` and `Handshake` in the decode stage; this module SHALL register nothing derived from `PCHold`.
REQ-022 `Stage` SHALL never hold at 0, 1 or 2.
REQ-023 IR SHALL never change except at an unheld `Stage`==3 edge or on reset.

Reset
REQ-024 `reset` SHALL be synchronous and active-high, and SHALL override all other inputs including `PCHold`.
REQ-025 On a `reset` edge, the module SHALL load PC<=8'hFF, `Stage`<=0, IR<=12'h000, `Valid`<=0, and both synchroniser flops<=0.
REQ-026 After reset release, `ProgAddr` SHALL be 8'h00; the first unheld `Stage`==3 edge SHALL load word 0, with PC=8'h00 and `Valid`=1.
REQ-027 `reset` asserted mid-slot or during a hold SHALL take effect on the next edge, abandoning the current instruction.

Verification
REQ-028 Reset then 8 clocks with ROM[0]=12'hABC, ROM[1]=12'h123 and `PCHold`=0 -> `Stage` 0,1,2,3,0,1,2,3, `Valid` rises after cycle 4, `Instruction`=12'hABC with `PC`=0, then 12'h123 with `PC`=1 after cycle 8.
REQ-029 `PCHold`=1 driven during stages 0-2 only -> no stall; `Stage` cycles unchanged.
REQ-030 `PCHold`=1 at `Stage`==3 for 5 cycles, then 0 -> `Stage`=3 for 6 cycles total, IR/PC unchanged, then `Stage`=0 with the next word loaded.
REQ-031 Force PC to 8'hFE and run 2 slots -> `ProgAddr` goes 8'hFF then 8'h00, and PC wraps to 8'h00.
REQ-032 `HandshakeIn` toggled 0->1 mid-cycle -> `Handshake`=1 exactly 2 edges later, including during a hold.
REQ-033 `reset` asserted during a hold at `Stage`==3 -> next cycle `Stage`=0, PC=8'hFF, `Valid`=0, `ProgAddr`=0.
